// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix-keypad scanner.
// The block strobes active-low columns and samples active-low rows through a
// two-flop synchroniser. One key per cycle is debounced serially, and press
// events are queued in a small valid/ready FIFO.
// Optional build macro: KEYPAD_RELEASE_EVT_EN. When it is defined, release
// events (evt_release=1) are also queued. When it is undefined, only presses
// are queued and evt_release is tied 0.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROWS-1:0]              rows,
  output logic [COLS-1:0]              cols,
  output logic [ROWS*COLS-1:0]         key_state,
  output logic                         any_key,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0] evt_code,
  output logic                         evt_release,
  output logic                         evt_ovf,
  input  logic                         ovf_clr
);

  localparam int NK = ROWS * COLS;
  localparam int KW = $clog2(NK);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int EW = KW + 1;
`else
  localparam int EW = KW;
`endif

  // Scan control
  logic [COLS-1:0] r_cols;
  logic [CW-1:0]   r_col_sel;
  logic [DW-1:0]   r_dwell;
  logic            w_dwell_wrap;
  logic            w_col_last;

  // Synchroniser and per-column snapshot
  logic [ROWS-1:0] r_rows_p0;
  logic [ROWS-1:0] r_rows_p1;
  logic [ROWS-1:0] r_row_snap;
  logic [CW-1:0]   r_snap_col;

  // Serial debounce
  logic [NK-1:0]   r_key_state;
  logic [3:0]      r_cnt [NK];
  logic            w_dbc_act;
  logic [RW-1:0]   w_row;
  logic [KW-1:0]   w_key;
  logic            w_sample;
  logic            w_differ;
  logic            w_toggle;
  logic            w_evt;

  // Event staging register between debounce and FIFO
  logic            r_push_vld_p0;
  logic [KW-1:0]   r_push_code_p0;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic            r_push_rel_p0;
`endif

  // Event FIFO
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic            r_ovf;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   w_head;

  assign w_dwell_wrap = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_col_last   = (r_col_sel == CW'(COLS - 1));

  // Column strobe register, dwell timer and column selector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cols    <= '1;
      r_col_sel <= '0;
      r_dwell   <= '0;
    end else begin
      r_cols <= ~(COLS'(1) << r_col_sel);
      if (w_dwell_wrap) begin
        r_dwell   <= '0;
        r_col_sel <= w_col_last ? '0 : r_col_sel + CW'(1);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Stage p0/p1: row synchroniser. The snapshot is taken at the end of each
  // column's dwell, so the rows have had the whole dwell to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows_p0  <= '1;
      r_rows_p1  <= '1;
      r_row_snap <= '1;
      r_snap_col <= '0;
    end else begin
      r_rows_p0 <= rows;
      r_rows_p1 <= r_rows_p0;
      if (w_dwell_wrap) begin
        r_row_snap <= r_rows_p1;
        r_snap_col <= r_col_sel;
      end
    end
  end

  // One snapshot row is processed per cycle during the first ROWS dwell
  // cycles of the next column. Only one key can toggle per cycle, so at most
  // one event is produced per cycle.
  assign w_dbc_act = (r_dwell < DW'(ROWS));
  assign w_row     = r_dwell[RW-1:0];
  assign w_key     = KW'(w_row) * KW'(COLS) + KW'(r_snap_col);
  assign w_sample  = ~r_row_snap[w_row];
  assign w_differ  = (w_sample != r_key_state[w_key]);
  assign w_toggle  = w_dbc_act && w_differ && (r_cnt[w_key] == 4'(DEBOUNCE_N - 1));
`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_evt     = w_toggle;
`else
  assign w_evt     = w_toggle && w_sample;
`endif

  // Per-key debounce counters and debounced key map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_state   <= '0;
      r_push_vld_p0 <= 1'b0;
      for (int i = 0; i < NK; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_push_vld_p0 <= w_evt;
      if (w_dbc_act) begin
        if (!w_differ) begin
          r_cnt[w_key] <= '0;
        end else if (w_toggle) begin
          r_key_state[w_key] <= w_sample;
          r_cnt[w_key]       <= '0;
        end else begin
          r_cnt[w_key] <= r_cnt[w_key] + 4'd1;
        end
      end
    end
  end

  // Stage p0: event payload, qualified by r_push_vld_p0.
  always_ff @(posedge clk) begin
    if (w_toggle) begin
      r_push_code_p0 <= w_key;
`ifdef KEYPAD_RELEASE_EVT_EN
      r_push_rel_p0  <= ~w_sample;
`endif
    end
  end

  // A push into a full FIFO is accepted only if a pop frees a slot in the
  // same cycle. There is no bypass from push to output.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_push  = r_push_vld_p0 && (!w_full || w_pop);
`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_entry = {r_push_rel_p0, r_push_code_p0};
`else
  assign w_entry = r_push_code_p0;
`endif
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // FIFO pointers and sticky overflow flag. A simultaneous overflow wins
  // over ovf_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (r_push_vld_p0 && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_entry;
    end
  end

  assign cols      = r_cols;
  assign key_state = r_key_state;
  assign any_key   = |r_key_state;
  assign evt_valid = !w_empty;
  assign evt_code  = w_empty ? '0 : w_head[KW-1:0];
`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt_release = !w_empty && w_head[KW];
`else
  assign evt_release = 1'b0;
`endif
  assign evt_ovf   = r_ovf;

endmodule
